// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the multiplexed seven-segment driver.
//   scan_state_e : per-slot phase (dead time vs. drive)
//   idx_w()      : width of the digit index for a given digit count
//   off_level()  : inactive drive level for a bus of the given width
package seven_seg_pkg;

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } scan_state_e;

  function automatic int unsigned idx_w(input int unsigned digits);
    return (digits > 2) ? $clog2(digits) : 1;
  endfunction

  // All ones for active-low pins, all zeros otherwise; only the low
  // `width` bits are meaningful to the caller.
  function automatic logic [63:0] off_level(input bit active_low,
                                            input int unsigned width);
    logic [63:0] v;
    v = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < width) v[i] = active_low;
    end
    return v;
  endfunction

endpackage

// File: rtl/seven_seg_prescaler.sv
// Slot timer for the multiplexed display.
//   clk, rst (async, active-low), en : clock, reset, scan enable
//   cnt        : position inside the current slot (0..FREQ)
//   digit_idx  : digit owning the current slot
//   sig        : one-cycle pulse in the first cycle of every slot
//   frame      : one-cycle pulse in the first cycle of digit 0's slot
//   slot_end   : combinational, the current cycle is the last of its slot
//   wrap       : combinational, the slot ending now hands over to digit 0
module seven_seg_prescaler
  import seven_seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int FREQ   = 17500,
  parameter int CBITS  = 15,
  parameter int IDXW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CBITS-1:0] cnt,
  output logic [IDXW-1:0]  digit_idx,
  output logic             sig,
  output logic             frame,
  output logic             slot_end,
  output logic             wrap
);

  logic term;
  logic last_digit;

  assign term       = (cnt == CBITS'(FREQ));
  assign last_digit = (digit_idx == IDXW'(DIGITS - 1));
  assign slot_end   = en && term;
  assign wrap       = slot_end && last_digit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      digit_idx <= '0;
      sig       <= 1'b0;
      frame     <= 1'b0;
    end else begin
      sig   <= 1'b0;
      frame <= 1'b0;
      if (en) begin
        if (term) begin
          cnt       <= '0;
          digit_idx <= last_digit ? '0 : digit_idx + 1'b1;
          sig       <= 1'b1;
          frame     <= last_digit;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seven_seg_mux.sv
// N-digit time-multiplexed seven-segment driver with dead time, per-digit
// blanking and frame-synchronous double buffering.
//   clk, rst (async, active-low), en : clock, reset, scan enable
//   both7seg   : packed segment patterns, digit k at [k*SEG_W +: SEG_W]
//   load       : capture both7seg; becomes visible from the next digit 0
//   digit_mask : 1 forces the corresponding digit dark
//   segment    : registered segment drive (inverted when ACTIVE_LOW)
//   digit_sel  : registered one-hot anode drive (inverted when ACTIVE_LOW)
//   digit_idx  : index of the current slot
//   sig, frame : slot-change and frame-start pulses
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SEG_W      = 7,
  parameter int FREQ       = 17500,
  parameter int CBITS      = 15,
  parameter int BLANK      = 16,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [DIGITS*SEG_W-1:0]   both7seg,
  input  logic                      load,
  input  logic [DIGITS-1:0]         digit_mask,
  output logic [SEG_W-1:0]          segment,
  output logic [DIGITS-1:0]         digit_sel,
  output logic [$clog2(DIGITS)-1:0] digit_idx,
  output logic                      sig,
  output logic                      frame
);

  localparam int unsigned IDXW = idx_w(DIGITS);
  localparam logic [SEG_W-1:0]  SEG_OFF = SEG_W'(off_level(ACTIVE_LOW != 0, SEG_W));
  localparam logic [DIGITS-1:0] SEL_OFF = DIGITS'(off_level(ACTIVE_LOW != 0, DIGITS));
  localparam scan_state_e SLOT_START = (BLANK > 0) ? ST_BLANK : ST_DRIVE;

  logic [CBITS-1:0] cnt;
  logic             slot_end;
  logic             wrap;

  seven_seg_prescaler #(
    .DIGITS (DIGITS),
    .FREQ   (FREQ),
    .CBITS  (CBITS),
    .IDXW   (IDXW)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cnt       (cnt),
    .digit_idx (digit_idx),
    .sig       (sig),
    .frame     (frame),
    .slot_end  (slot_end),
    .wrap      (wrap)
  );

  // Double buffer: the shadow copy is only promoted on the wrap to digit 0,
  // so a frame never mixes old and new patterns.
  logic [DIGITS*SEG_W-1:0] shadow_q;
  logic [DIGITS*SEG_W-1:0] active_q;
  logic                    pending_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else if (load) begin
      shadow_q <= both7seg;
      if (wrap) begin
        active_q  <= both7seg;
        pending_q <= 1'b0;
      end else begin
        pending_q <= 1'b1;
      end
    end else if (wrap && pending_q) begin
      active_q  <= shadow_q;
      pending_q <= 1'b0;
    end
  end

  // Slot FSM: state_q always describes the slot phase of the current cnt,
  // tracking it edge by edge rather than decoding cnt directly.
  scan_state_e      state_q, state_d;
  logic [SEG_W-1:0]  seg_d;
  logic [DIGITS-1:0] sel_d;
  logic [SEG_W-1:0]  cur_pattern;
  logic [DIGITS-1:0] onehot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SLOT_START;
      segment   <= SEG_OFF;
      digit_sel <= SEL_OFF;
    end else begin
      state_q   <= state_d;
      segment   <= seg_d;
      digit_sel <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (slot_end) begin
      state_d = SLOT_START;
    end else if (en && state_q == ST_BLANK && cnt == CBITS'(BLANK - 1)) begin
      state_d = ST_DRIVE;
    end
  end

  assign cur_pattern = active_q[digit_idx*SEG_W +: SEG_W];
  assign onehot      = DIGITS'(1) << digit_idx;

  // A masked digit still owns its slot, only the drive is suppressed.
  always_comb begin
    seg_d = SEG_OFF;
    sel_d = SEL_OFF;
    if (en && state_q == ST_DRIVE && !digit_mask[digit_idx]) begin
      seg_d = cur_pattern ^ SEG_OFF;
      sel_d = onehot ^ SEL_OFF;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux.sv
module tb_seven_seg_mux;

  localparam int DIGITS = 4;
  localparam int SEG_W  = 7;
  localparam int FREQ   = 3;
  localparam int CBITS  = 4;
  localparam int BLANK  = 1;
  localparam int SLOT   = FREQ + 1;
  localparam int FRAME_LEN = SLOT * DIGITS;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic                    load;
  logic [DIGITS*SEG_W-1:0] both7seg;
  logic [DIGITS-1:0]       digit_mask;

  logic [SEG_W-1:0]  seg0, seg1;
  logic [DIGITS-1:0] sel0, sel1;
  logic [1:0]        idx0, idx1;
  logic              sig0, sig1, frame0, frame1;

  seven_seg_mux #(
    .DIGITS(DIGITS), .SEG_W(SEG_W), .FREQ(FREQ), .CBITS(CBITS),
    .BLANK(BLANK), .ACTIVE_LOW(0)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .both7seg(both7seg), .load(load),
    .digit_mask(digit_mask), .segment(seg0), .digit_sel(sel0),
    .digit_idx(idx0), .sig(sig0), .frame(frame0)
  );

  seven_seg_mux #(
    .DIGITS(DIGITS), .SEG_W(SEG_W), .FREQ(FREQ), .CBITS(CBITS),
    .BLANK(BLANK), .ACTIVE_LOW(1)
  ) u_dut_inv (
    .clk(clk), .rst(rst), .en(en), .both7seg(both7seg), .load(load),
    .digit_mask(digit_mask), .segment(seg1), .digit_sel(sel1),
    .digit_idx(idx1), .sig(sig1), .frame(frame1)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: elapsed enabled cycles since reset, modulo one frame.
  int unsigned             tick;
  logic [DIGITS*SEG_W-1:0] m_active;
  logic [DIGITS*SEG_W-1:0] m_shadow;
  bit                      m_pending;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned m_cnt();
    return tick % SLOT;
  endfunction

  function automatic int unsigned m_digit();
    return (tick / SLOT) % DIGITS;
  endfunction

  task automatic model_reset();
    tick      = 0;
    m_active  = '0;
    m_shadow  = '0;
    m_pending = 0;
  endtask

  // One clock: drive inputs, predict the post-edge outputs, compare.
  task automatic step(input logic e, input logic l,
                      input logic [DIGITS*SEG_W-1:0] d,
                      input logic [DIGITS-1:0] m);
    int unsigned       c, g, e_idx;
    logic [SEG_W-1:0]  e_seg, inv_seg;
    logic [DIGITS-1:0] e_sel, inv_sel;
    logic              e_sig, e_frame;
    en = e; load = l; both7seg = d; digit_mask = m;
    c = m_cnt();
    g = m_digit();
    e_seg = '0;
    e_sel = '0;
    if (e && c >= BLANK && !m[g]) begin
      e_seg = m_active[g*SEG_W +: SEG_W];
      e_sel = DIGITS'(1 << g);
    end
    e_sig   = e && (c == FREQ);
    e_frame = e_sig && (g == DIGITS - 1);
    if (e) tick = (tick + 1) % FRAME_LEN;
    e_idx = m_digit();
    if (l) begin
      m_shadow = d;
      if (e_frame) begin
        m_active  = d;
        m_pending = 0;
      end else begin
        m_pending = 1;
      end
    end else if (e_frame && m_pending) begin
      m_active  = m_shadow;
      m_pending = 0;
    end
    inv_seg = ~e_seg;
    inv_sel = ~e_sel;
    @(posedge clk);
    #1;
    check("segment",       seg0,   e_seg);
    check("digit_sel",     sel0,   e_sel);
    check("digit_idx",     idx0,   e_idx);
    check("sig",           sig0,   e_sig);
    check("frame",         frame0, e_frame);
    check("segment_inv",   seg1,   inv_seg);
    check("digit_sel_inv", sel1,   inv_sel);
    check("digit_idx_inv", idx1,   e_idx);
    check("sig_inv",       sig1,   e_sig);
  endtask

  task automatic check_off(input string tag);
    check({tag, "_segment"},     seg0,   '0);
    check({tag, "_digit_sel"},   sel0,   '0);
    check({tag, "_digit_idx"},   idx0,   0);
    check({tag, "_sig"},         sig0,   0);
    check({tag, "_frame"},       frame0, 0);
    check({tag, "_segment_inv"}, seg1,   32'h7F);
    check({tag, "_sel_inv"},     sel1,   32'hF);
  endtask

  function automatic logic [DIGITS*SEG_W-1:0] rnd_pat();
    return (DIGITS*SEG_W)'($urandom);
  endfunction

  localparam logic [DIGITS*SEG_W-1:0] PAT0 = {7'h4F, 7'h5B, 7'h06, 7'h3F};
  localparam logic [DIGITS*SEG_W-1:0] PAT1 = {7'h66, 7'h6D, 7'h7D, 7'h07};
  localparam logic [DIGITS*SEG_W-1:0] PAT2 = {7'h7F, 7'h6F, 7'h77, 7'h39};

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; both7seg = '0; digit_mask = '0;
    model_reset();
    #12;
    check_off("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic scan with distinct patterns.
    step(1, 1, PAT0, '0);
    for (int i = 0; i < 40; i++) step(1, 0, rnd_pat(), '0);

    // Load mid-frame while digit 1 is being driven.
    for (int i = 0; i < 64 && !(m_digit() == 1 && m_cnt() == 2); i++)
      step(1, 0, rnd_pat(), '0);
    check("wait_digit1", (m_digit() == 1 && m_cnt() == 2), 1);
    step(1, 1, PAT1, '0);
    for (int i = 0; i < 24; i++) step(1, 0, rnd_pat(), '0);

    // Load exactly in the wrap cycle.
    for (int i = 0; i < 64 && !(m_digit() == 3 && m_cnt() == FREQ); i++)
      step(1, 0, rnd_pat(), '0);
    check("wait_wrap", (m_digit() == 3 && m_cnt() == FREQ), 1);
    step(1, 1, PAT2, '0);
    for (int i = 0; i < 20; i++) step(1, 0, rnd_pat(), '0);

    // Digit 2 masked.
    for (int i = 0; i < 24; i++) step(1, 0, rnd_pat(), 4'b0100);

    // Scan paused mid-drive.
    for (int i = 0; i < 64 && m_cnt() != 2; i++) step(1, 0, rnd_pat(), '0);
    check("wait_drive", (m_cnt() == 2), 1);
    for (int i = 0; i < 10; i++) step(0, 0, rnd_pat(), '0);
    for (int i = 0; i < 20; i++) step(1, 0, rnd_pat(), '0);

    // Asynchronous reset while digit 3 is lit.
    for (int i = 0; i < 64 && !(m_digit() == 3 && m_cnt() == 2); i++)
      step(1, 0, rnd_pat(), '0);
    check("wait_digit3", (m_digit() == 3 && m_cnt() == 2), 1);
    #3;
    rst = 1'b0;
    #1;
    check_off("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, 1, PAT1, '0);
    for (int i = 0; i < 24; i++) step(1, 0, rnd_pat(), '0);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      logic              e, l;
      logic [DIGITS-1:0] m;
      e = ($urandom % 10) != 0;
      l = ($urandom % 8) == 0;
      m = (($urandom % 4) == 0) ? DIGITS'($urandom) : '0;
      step(e, l, rnd_pat(), m);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
